nand_read_ctrl: RTL and testbench
=================================

NAND_READ_CTRL -- requirements
Module: nand_read_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: NAND I/O width, 8 or 16.
REQ-002 The block SHALL have parameter ADDR_CYC, default 5: address cycles per read, 1..8.
REQ-003 The block SHALL have parameter LEN_W, default 16: width of the transfer length.
REQ-004 The block SHALL have parameter RE_LO, default 2: clk cycles nand_re_n is low per pulse, at least 1.
REQ-005 The block SHALL have parameter RE_HI, default 1: minimum clk cycles nand_re_n is high between pulses, at least 1.
REQ-006 The block SHALL have parameter TWB, default 4: clk cycles after the second command before rb is sampled.
REQ-007 The block SHALL have parameter RB_TMO, default 65535: maximum clk cycles spent waiting for rb high.
REQ-008 clk  in  1  clock; all sequential logic is on the rising edge.
REQ-009 rst  in  1  reset; asynchronous, active-high.
REQ-010 start  in  1  one-cycle read request; sampled only when busy=0.
REQ-011 addr  in  8*ADDR_CYC  page/column address; address cycle 0 = addr[7:0].
REQ-012 length  in  LEN_W  number of DATA_W words to read.
REQ-013 busy  out  1  operation in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  rb timeout flag; valid with done, held until the next start.
REQ-016 nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n  out  1 each  NAND control pins.
REQ-017 nand_rb_n  in  1  ready/busy, low = busy; two-flop synchronised internally.
REQ-018 nand_io_o  out  DATA_W; nand_io_oe  out  1; nand_io_i  in  DATA_W  split tristate I/O bus.
REQ-019 m_data  out  DATA_W; m_valid  out  1; m_ready  in  1  read-data stream.
REQ-020 crc  out  16  CRC of the streamed data (see Configuration).

Function
REQ-021 The FSM SHALL have states IDLE, CMD1, ADDR, CMD2, TWB, WAIT_RB, READ and FIN; IDLE goes to CMD1 on start, and addr and length are latched at that point.
REQ-022 Each command or address cycle SHALL last 2 clk: nand_we_n low for the first clk and high for the second, with nand_io_o stable and nand_io_oe=1 throughout; nand_cle=1 in CMD1/CMD2 and nand_ale=1 in ADDR.
REQ-023 The bus sequence SHALL be: CMD1 drives 8'h00; ADDR drives ADDR_CYC bytes, LSB byte first; CMD2 drives 8'h30; the upper DATA_W-8 bits are driven 0.
REQ-024 TWB SHALL count TWB cycles; WAIT_RB then waits for synchronised rb=1 and, if RB_TMO cycles elapse first, sets err=1 and goes to FIN.
REQ-025 In READ, each pulse SHALL hold nand_re_n low for RE_LO cycles; nand_io_i is captured into m_data, and m_valid is set, on the edge that returns nand_re_n high.
REQ-026 A new pulse SHALL start only when nand_re_n has been high for at least RE_HI cycles and the output register is empty or consumed (m_ready=1) in that cycle; m_data stays stable while m_valid=1 and m_ready=0.
REQ-027 After the length-th capture, the FSM SHALL go to FIN when that word is accepted (m_valid and m_ready both high).
REQ-028 If length=0, WAIT_RB SHALL go directly to FIN with no nand_re_n pulse.
REQ-029 nand_ce_n SHALL be 0 from CMD1 through READ and 1 in FIN and IDLE; nand_io_oe SHALL be 0 outside CMD1, ADDR and CMD2.
REQ-030 busy SHALL be 1 from the cycle after start through FIN; done SHALL pulse once in FIN; start while busy=1 is ignored.

Reset
REQ-031 While rst=1: state=IDLE, nand_ce_n=1, nand_we_n=1, nand_re_n=1, nand_cle=0, nand_ale=0, nand_io_oe=0, nand_io_o=0, m_valid=0, m_data=0, busy=0, done=0, err=0, crc=16'hFFFF, and all counters are 0.
REQ-032 rst asserted mid-operation SHALL abandon the transfer without a done pulse; the next start begins afresh from CMD1.

Configuration
REQ-033 With NAND_RD_CRC_EN defined, crc SHALL be CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, all DATA_W bits) over accepted stream words; it is set to 0xFFFF on start and holds its final value from done until the next start.
REQ-034 With NAND_RD_CRC_EN undefined, the block SHALL contain no CRC logic and crc SHALL be tied to 16'h0000.

Structure
REQ-035 Package nand_pkg SHALL hold the state enum, CMD_READ1=8'h00, CMD_READ2=8'h30 and CRC_POLY=16'h1021.
REQ-036 Sub-module nand_crc16 (combinational per-word update, parameter DATA_W) SHALL be instantiated only under NAND_RD_CRC_EN.

Verification
REQ-037 Nominal read: DATA_W=8, addr=40'h0102030405, length=4, rb low for 10 cycles, model returns A0..A3, m_ready=1 -> nand_io_o sequence 00,05,04,03,02,01,30; m_data A0,A1,A2,A3; one done; err=0.
REQ-038 Back-pressure: m_ready=0 for 6 cycles after the first word -> m_valid held, m_data stable, no nand_re_n falling edge in that window; all 4 words delivered in order.
REQ-039 Timeout: rb stuck low with RB_TMO=100 -> done with err=1 100 cycles after TWB ends; no nand_re_n pulse; nand_ce_n=1.
REQ-040 Zero length: length=0 -> full command/address sequence, zero nand_re_n pulses, done with err=0.
REQ-041 Mid-read reset: rst asserted in READ after 2 of 4 words -> reset values immediately and no done; a new start with length=2 completes normally.
REQ-042 CRC: NAND_RD_CRC_EN defined, words 8'h31..8'h39 (9 words) -> crc=16'h29B1 at done.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND page-read controller.
package nand_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd1,
      StAddr,
      StCmd2,
      StTwb,
      StWaitRb,
      StRead,
      StFin
   } nand_state_e;

   localparam logic [7:0]  CMD_READ1 = 8'h00;
   localparam logic [7:0]  CMD_READ2 = 8'h30;
   localparam logic [15:0] CRC_POLY  = 16'h1021;

endpackage

// File: rtl/nand_read_ctrl_if.sv
// Host, NAND-pin and read-stream signals of the NAND page-read controller.
interface nand_read_ctrl_if #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_CYC = 5,
   parameter int unsigned LEN_W    = 16
);
   logic                  start;
   logic [8*ADDR_CYC-1:0] addr;
   logic [LEN_W-1:0]      length;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic                  nand_ce_n;
   logic                  nand_cle;
   logic                  nand_ale;
   logic                  nand_we_n;
   logic                  nand_re_n;
   logic                  nand_rb_n;
   logic [DATA_W-1:0]     nand_io_o;
   logic                  nand_io_oe;
   logic [DATA_W-1:0]     nand_io_i;
   logic [DATA_W-1:0]     m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [15:0]           crc;

   // Controller side.
   modport slave (
      input  start, addr, length, nand_rb_n, nand_io_i, m_ready,
      output busy, done, err, nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n,
      output nand_io_o, nand_io_oe, m_data, m_valid, crc
   );

   // Host / NAND-device side.
   modport master (
      output start, addr, length, nand_rb_n, nand_io_i, m_ready,
      input  busy, done, err, nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n,
      input  nand_io_o, nand_io_oe, m_data, m_valid, crc
   );

endinterface

// File: rtl/nand_crc16.sv
// Combinational CRC-16-CCITT update over one DATA_W-bit word, MSB first.
module nand_crc16
   import nand_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [15:0]       crc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [15:0]       crc_o
);

   always_comb begin
      crc_o = crc_i;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (crc_o[15] ^ data_i[i]) begin
            crc_o = (crc_o << 1) ^ CRC_POLY;
         end else begin
            crc_o = crc_o << 1;
         end
      end
   end

endmodule

// File: rtl/nand_read_ctrl.sv
// NAND page-read controller: 00h/address/30h sequence, tWB + R/B# wait, paced RE# stream.
// Define NAND_RD_CRC_EN to add a CRC-16-CCITT over the accepted stream words.
module nand_read_ctrl
   import nand_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_CYC = 5,
   parameter int unsigned LEN_W    = 16,
   parameter int unsigned RE_LO    = 2,
   parameter int unsigned RE_HI    = 1,
   parameter int unsigned TWB      = 4,
   parameter int unsigned RB_TMO   = 65535
) (
   input logic             clk,
   input logic             rst,
   nand_read_ctrl_if.slave bus
);

   localparam int unsigned CntW = $clog2(RB_TMO + TWB + RE_LO + RE_HI + 2);

   nand_state_e           state_q;
   logic [8*ADDR_CYC-1:0] addr_q;
   logic [LEN_W-1:0]      len_q, words_q;
   logic [3:0]            byte_q;
   logic                  ph_q;
   logic [CntW-1:0]       cnt_q;
   logic                  rb_s1_q, rb_s2_q;
   logic                  ce_n_q, cle_q, ale_q, we_n_q, re_n_q, oe_q;
   logic [DATA_W-1:0]     io_q, mdata_q;
   logic                  mvalid_q, busy_q, done_q, err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rb_s1_q <= 1'b0;
         rb_s2_q <= 1'b0;
      end else begin
         rb_s1_q <= bus.nand_rb_n;
         rb_s2_q <= rb_s1_q;
      end
   end

   // ph_q splits each command/address cycle into a WE#-low and a WE#-high clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         len_q    <= '0;
         words_q  <= '0;
         byte_q   <= '0;
         ph_q     <= 1'b0;
         cnt_q    <= '0;
         ce_n_q   <= 1'b1;
         cle_q    <= 1'b0;
         ale_q    <= 1'b0;
         we_n_q   <= 1'b1;
         re_n_q   <= 1'b1;
         oe_q     <= 1'b0;
         io_q     <= '0;
         mdata_q  <= '0;
         mvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  addr_q  <= bus.addr;
                  len_q   <= bus.length;
                  words_q <= '0;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  ce_n_q  <= 1'b0;
                  cle_q   <= 1'b1;
                  we_n_q  <= 1'b0;
                  oe_q    <= 1'b1;
                  io_q    <= DATA_W'(CMD_READ1);
                  ph_q    <= 1'b0;
                  state_q <= StCmd1;
               end
            end
            StCmd1: begin
               if (!ph_q) begin
                  we_n_q <= 1'b1;
                  ph_q   <= 1'b1;
               end else begin
                  cle_q   <= 1'b0;
                  ale_q   <= 1'b1;
                  we_n_q  <= 1'b0;
                  io_q    <= DATA_W'(addr_q[7:0]);
                  addr_q  <= addr_q >> 8;
                  byte_q  <= '0;
                  ph_q    <= 1'b0;
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (!ph_q) begin
                  we_n_q <= 1'b1;
                  ph_q   <= 1'b1;
               end else if (byte_q == 4'(ADDR_CYC - 1)) begin
                  ale_q   <= 1'b0;
                  cle_q   <= 1'b1;
                  we_n_q  <= 1'b0;
                  io_q    <= DATA_W'(CMD_READ2);
                  ph_q    <= 1'b0;
                  state_q <= StCmd2;
               end else begin
                  byte_q <= byte_q + 1'b1;
                  we_n_q <= 1'b0;
                  io_q   <= DATA_W'(addr_q[7:0]);
                  addr_q <= addr_q >> 8;
                  ph_q   <= 1'b0;
               end
            end
            StCmd2: begin
               if (!ph_q) begin
                  we_n_q <= 1'b1;
                  ph_q   <= 1'b1;
               end else begin
                  cle_q   <= 1'b0;
                  oe_q    <= 1'b0;
                  io_q    <= '0;
                  ph_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StTwb;
               end
            end
            StTwb: begin
               if (cnt_q == CntW'(TWB - 1)) begin
                  cnt_q   <= '0;
                  state_q <= StWaitRb;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWaitRb: begin
               if (rb_s2_q && (len_q == '0)) begin
                  done_q  <= 1'b1;
                  ce_n_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StFin;
               end else if (rb_s2_q) begin
                  cnt_q   <= CntW'(RE_HI);
                  state_q <= StRead;
               end else if (cnt_q == CntW'(RB_TMO - 1)) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  ce_n_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StFin;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StRead: begin
               // cnt_q counts clocks spent at the current RE# level.
               if (mvalid_q && bus.m_ready) begin
                  mvalid_q <= 1'b0;
               end
               if (!re_n_q) begin
                  if (cnt_q == CntW'(RE_LO)) begin
                     re_n_q   <= 1'b1;
                     mdata_q  <= bus.nand_io_i;
                     mvalid_q <= 1'b1;
                     words_q  <= words_q + 1'b1;
                     cnt_q    <= CntW'(1);
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else if (mvalid_q && bus.m_ready && (words_q == len_q)) begin
                  done_q  <= 1'b1;
                  ce_n_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StFin;
               end else if ((cnt_q >= CntW'(RE_HI)) && (!mvalid_q || bus.m_ready) &&
                            (words_q != len_q)) begin
                  re_n_q <= 1'b0;
                  cnt_q  <= CntW'(1);
               end else if (cnt_q < CntW'(RE_HI)) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StFin: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.nand_ce_n  = ce_n_q;
   assign bus.nand_cle   = cle_q;
   assign bus.nand_ale   = ale_q;
   assign bus.nand_we_n  = we_n_q;
   assign bus.nand_re_n  = re_n_q;
   assign bus.nand_io_o  = io_q;
   assign bus.nand_io_oe = oe_q;
   assign bus.m_data     = mdata_q;
   assign bus.m_valid    = mvalid_q;

`ifdef NAND_RD_CRC_EN
   logic [15:0] crc_q, crc_upd;

   nand_crc16 #(
      .DATA_W(DATA_W)
   ) u_crc (
      .crc_i (crc_q),
      .data_i(mdata_q),
      .crc_o (crc_upd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= 16'hFFFF;
      end else if ((state_q == StIdle) && bus.start) begin
         crc_q <= 16'hFFFF;
      end else if ((state_q == StRead) && mvalid_q && bus.m_ready) begin
         crc_q <= crc_upd;
      end
   end

   assign bus.crc = crc_q;
`else
   assign bus.crc = 16'h0000;
`endif

endmodule

// File: tb/tb_nand_read_ctrl.sv
// Self-checking bench for nand_read_ctrl: table vectors, random reads and corner sequences.
module tb_nand_read_ctrl;

   localparam int unsigned DW   = 8;
   localparam int unsigned AC   = 5;
   localparam int unsigned LW   = 16;
   localparam int unsigned TWBP = 4;
   localparam int unsigned TMO  = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nand_read_ctrl_if #(.DATA_W(DW), .ADDR_CYC(AC), .LEN_W(LW)) bus ();

   nand_read_ctrl #(
      .DATA_W  (DW),
      .ADDR_CYC(AC),
      .LEN_W   (LW),
      .RE_LO   (2),
      .RE_HI   (1),
      .TWB     (TWBP),
      .RB_TMO  (TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // NAND device / stream sink model state
   logic [DW-1:0] words[$];
   logic [9:0]    bus_seen[$];
   logic [DW-1:0] got[$];
   int  rb_lo = 1, rb_cnt = 0, mode = 0;
   int  pulses = 0, dones = 0, rd_idx = 0, bp_left = 0, cyc = 0, cmd2_cyc = 0, done_cyc = 0;
   bit  bp_done = 0, held = 0, err_seen = 0, ce_at_done = 0;
   logic [DW-1:0] held_data = '0;
   logic prev_we = 1'b1, prev_re = 1'b1;

   function automatic logic [15:0] crc_ref(input int n);
      logic [15:0] c = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
         for (int b = DW - 1; b >= 0; b--) begin
            logic fb = c[15] ^ words[k][b];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   initial begin
      bus.start = 1'b0; bus.addr = '0; bus.length = '0;
      bus.nand_rb_n = 1'b1; bus.nand_io_i = '0; bus.m_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_we = 1'b1; prev_re = 1'b1; held = 0;
         end else begin
            if (!prev_we && bus.nand_we_n) begin
               bus_seen.push_back({bus.nand_cle, bus.nand_ale, bus.nand_io_o[7:0]});
               if (bus.nand_cle && bus.nand_io_o[7:0] == 8'h30) begin
                  bus.nand_rb_n = 1'b0; rb_cnt = rb_lo; cmd2_cyc = cyc;
               end
            end else if (!bus.nand_rb_n && rb_cnt > 0) begin
               rb_cnt--;
               if (rb_cnt == 0) bus.nand_rb_n = 1'b1;
            end
            if (held) begin
               chk("hold_valid", bus.m_valid, 1'b1);
               chk("hold_data", bus.m_data, held_data);
               chk("hold_no_re_fall", prev_re && !bus.nand_re_n, 1'b0);
            end
            if (prev_re && !bus.nand_re_n) pulses++;
            if (!prev_re && bus.nand_re_n) rd_idx++;
            if (bus.done) begin
               dones++; err_seen = bus.err; ce_at_done = bus.nand_ce_n; done_cyc = cyc;
            end
            prev_we = bus.nand_we_n;
            prev_re = bus.nand_re_n;
         end
         bus.nand_io_i = (rd_idx < words.size()) ? words[rd_idx] : '0;
         if (mode == 2 && !bp_done && bus.m_valid) begin
            bp_left = 6; bp_done = 1;
         end
         if (mode == 1) bus.m_ready = 1'($urandom_range(0, 1));
         else if (bp_left > 0) begin bus.m_ready = 1'b0; bp_left--; end
         else bus.m_ready = 1'b1;
         held = !rst && bus.m_valid && !bus.m_ready;
         held_data = bus.m_data;
         if (!rst && bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_ce_n"}, bus.nand_ce_n, 1'b1);
      chk({tag, "_we_n"}, bus.nand_we_n, 1'b1);
      chk({tag, "_re_n"}, bus.nand_re_n, 1'b1);
      chk({tag, "_cle_ale_oe"}, {bus.nand_cle, bus.nand_ale, bus.nand_io_oe}, 3'b000);
      chk({tag, "_io_o"}, bus.nand_io_o, '0);
      chk({tag, "_m_valid_data"}, {bus.m_valid, bus.m_data}, '0);
      chk({tag, "_busy_done_err"}, {bus.busy, bus.done, bus.err}, 3'b000);
`ifdef NAND_RD_CRC_EN
      chk({tag, "_crc"}, bus.crc, 16'hFFFF);
`else
      chk({tag, "_crc"}, bus.crc, 16'h0000);
`endif
   endtask

   task automatic launch(input logic [8*AC-1:0] a, input int len, input int rbl, input int md);
      bus_seen.delete(); got.delete();
      pulses = 0; dones = 0; rd_idx = 0; rb_lo = rbl; mode = md; bp_done = 0; bp_left = 0;
      bus.nand_rb_n = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b1; bus.addr = a; bus.length = LW'(len);
      @(negedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic run_txn(input string tag, input logic [8*AC-1:0] a, input int len,
                          input int rbl, input int md, input bit exp_err);
      logic [9:0] exp_bus[$];
      int n_exp, w;
      launch(a, len, rbl, md);
      chk({tag, "_busy"}, bus.busy, 1'b1);
      w = 0;
      while (dones == 0 && w < 3000) begin
         @(negedge clk); #2;
         w++;
         if (w == 3) begin bus.start = 1'b1; bus.length = LW'(7); end
         if (w == 4) bus.start = 1'b0;
      end
      chk({tag, "_done_seen"}, dones > 0, 1'b1);
      repeat (5) @(negedge clk);
      #2;
      chk({tag, "_done_once"}, dones, 1);
      chk({tag, "_err"}, err_seen, exp_err);
      chk({tag, "_idle"}, {bus.busy, bus.nand_ce_n}, 2'b01);
      exp_bus.push_back({2'b10, 8'h00});
      for (int i = 0; i < int'(AC); i++) exp_bus.push_back({2'b01, a[8*i +: 8]});
      exp_bus.push_back({2'b10, 8'h30});
      chk({tag, "_bus_len"}, bus_seen.size(), exp_bus.size());
      for (int i = 0; i < exp_bus.size() && i < bus_seen.size(); i++)
         chk($sformatf("%s_bus%0d", tag, i), bus_seen[i], exp_bus[i]);
      n_exp = exp_err ? 0 : len;
      chk({tag, "_pulses"}, pulses, n_exp);
      chk({tag, "_words"}, got.size(), n_exp);
      for (int i = 0; i < n_exp && i < got.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), got[i], words[i]);
`ifdef NAND_RD_CRC_EN
      chk({tag, "_crc"}, bus.crc, crc_ref(n_exp));
`else
      chk({tag, "_crc"}, bus.crc, 16'h0000);
`endif
      if (exp_err) begin
         chk({tag, "_ce_at_done"}, ce_at_done, 1'b1);
         chk({tag, "_tmo_latency"}, done_cyc - cmd2_cyc, 1 + TWBP + TMO);
      end
   endtask

   typedef struct {
      logic [39:0] addr;
      int          len;
      int          rb_lo;
      int          mode;
      bit          err;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{40'h0102030405,  4, 10, 0, 1'b0};  // nominal
      tbl[1] = '{40'h0102030405,  4, 10, 2, 1'b0};  // back-pressure
      tbl[2] = '{40'hA5C3_0F11_7E, 0,  5, 0, 1'b0};  // zero length
      tbl[3] = '{40'h1122334455,  3, -1, 0, 1'b1};  // rb stuck low

      repeat (3) @(negedge clk);
      #1 chk_reset("reset");
      rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         words.delete();
         for (int i = 0; i < tbl[v].len; i++) words.push_back(DW'(8'hA0 + i));
         run_txn($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].len, tbl[v].rb_lo,
                 tbl[v].mode, tbl[v].err);
      end

      words.delete();
      for (int i = 0; i < 9; i++) words.push_back(DW'(8'h31 + i));
      run_txn("crc9", 40'h0000000000, 9, 3, 0, 1'b0);

      for (int r = 0; r < 10; r++) begin
         int len = $urandom_range(0, 5);
         words.delete();
         for (int i = 0; i < len; i++) words.push_back(DW'($urandom));
         run_txn($sformatf("rnd%0d", r), {8'($urandom), 32'($urandom)}, len,
                 $urandom_range(1, 12), $urandom_range(0, 1), 1'b0);
      end

      // Reset in the middle of a read, then a clean restart.
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(DW'(8'hC0 + i));
      launch(40'h0A0B0C0D0E, 4, 3, 0);
      for (int w = 0; w < 500 && got.size() < 2; w++) @(negedge clk);
      chk("midrst_two_words", got.size() >= 2, 1'b1);
      #2 rst = 1'b1;
      #1 chk_reset("midrst");
      repeat (3) @(negedge clk);
      chk("midrst_no_done", dones, 0);
      rst = 1'b0;
      words.delete();
      words.push_back(DW'(8'h5A));
      words.push_back(DW'(8'hE7));
      run_txn("after_rst", 40'h0102030405, 2, 4, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
